// File: rtl/pid_math_seq_if.sv
// pid_math_seq_if: signal bundle between the PID math sequencer, the shared
// 16-bit ALU and the A2D/drive environment.
//   master : the sequencer. Takes start/clear, sensor and gain inputs and the
//            ALU result. Drives the ALU selects/controls, the working registers
//            and busy/done.
//   slave  : the environment (front end + ALU) side of the same signals.
interface pid_math_seq_if;
  logic        strt;
  logic        clr_intgrl;
  logic [11:0] A2D_res;
  logic [11:0] Fwd;
  logic [13:0] Pterm;
  logic [11:0] Iterm;
  logic [15:0] dst;
  logic [2:0]  src1sel;
  logic [2:0]  src0sel;
  logic        multiply;
  logic        sub;
  logic        mult2;
  logic        mult4;
  logic        saturate;
  logic [11:0] Error;
  logic [11:0] Intgrl;
  logic [11:0] Icomp;
  logic [15:0] Pcomp;
  logic [15:0] Accum;
  logic        busy;
  logic        done;

  modport master (
    input  strt, clr_intgrl, A2D_res, Fwd, Pterm, Iterm, dst,
    output src1sel, src0sel, multiply, sub, mult2, mult4, saturate,
    output Error, Intgrl, Icomp, Pcomp, Accum, busy, done
  );

  modport slave (
    output strt, clr_intgrl, A2D_res, Fwd, Pterm, Iterm, dst,
    input  src1sel, src0sel, multiply, sub, mult2, mult4, saturate,
    input  Error, Intgrl, Icomp, Pcomp, Accum, busy, done
  );
endinterface

// File: rtl/pid_math_seq.sv
// pid_math_seq: sequencer for the shared 16-bit PID ALU. Each accepted start
// walks the ALU through ERR, INTG, ICMP, PCMP, ACC1 and ACC2 and captures dst
// into Error, Intgrl, Icomp, Pcomp and Accum. Accum is the drive command,
// valid when done pulses.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    pid_math_seq_if.master: strt/clr_intgrl and the sensor and gain
//          inputs, dst from the ALU, the ALU selects/controls, the working
//          registers, and busy/done
// Parameters:
//   MULT_CYC  cycles that each multiply step holds its selects (>=1)
//   INT_DEC   Intgrl is written on every INT_DEC-th sequence (>=1)
module pid_math_seq #(
  parameter int unsigned MULT_CYC = 2,
  parameter int unsigned INT_DEC  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pid_math_seq_if.master    bus
);

  typedef enum logic [2:0] {IDLE, ERR, INTG, ICMP, PCMP, ACC1, ACC2} state_t;

  localparam int unsigned MW = (MULT_CYC > 1) ? $clog2(MULT_CYC) : 1;
  localparam int unsigned DW = (INT_DEC > 1) ? $clog2(INT_DEC) : 1;
  localparam logic [MW-1:0] MULT_LD = MW'(MULT_CYC - 1);
  localparam logic [DW-1:0] DEC_TOP = DW'(INT_DEC - 1);

  state_t        state, nxt_state;
  logic [MW-1:0] mult_cnt;
  logic [DW-1:0] dec_cnt;
  logic          mult_st;
  logic          mult_last;

  assign mult_st   = (state == ICMP) || (state == PCMP);
  assign mult_last = (mult_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  // Moore decode: selects and controls depend on the state register only.
  always_comb begin
    nxt_state    = state;
    bus.src1sel  = '0;
    bus.src0sel  = '0;
    bus.multiply = 1'b0;
    bus.sub      = 1'b0;
    bus.saturate = 1'b0;
    case (state)
      IDLE: if (bus.strt) nxt_state = ERR;
      ERR: begin
        bus.src1sel  = 3'd4;
        bus.src0sel  = 3'd0;
        bus.sub      = 1'b1;
        bus.saturate = 1'b1;
        nxt_state    = INTG;
      end
      INTG: begin
        bus.src1sel  = 3'd3;
        bus.src0sel  = 3'd1;
        bus.saturate = 1'b1;
        nxt_state    = ICMP;
      end
      ICMP: begin
        bus.src1sel  = 3'd1;
        bus.src0sel  = 3'd1;
        bus.multiply = 1'b1;
        if (mult_last) nxt_state = PCMP;
      end
      PCMP: begin
        bus.src1sel  = 3'd2;
        bus.src0sel  = 3'd4;
        bus.multiply = 1'b1;
        if (mult_last) nxt_state = ACC1;
      end
      ACC1: begin
        bus.src1sel = 3'd4;
        bus.src0sel = 3'd3;
        nxt_state   = ACC2;
      end
      ACC2: begin
        bus.src1sel  = 3'd0;
        bus.src0sel  = 3'd2;
        bus.saturate = 1'b1;
        nxt_state    = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign bus.mult2 = 1'b0;
  assign bus.mult4 = 1'b0;
  assign bus.busy  = (state != IDLE);

  // Held at MULT_LD whenever no multiply is counting, so it already holds the
  // reload value on entry to ICMP and again on the ICMP->PCMP hand-over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    mult_cnt <= '0;
    else if (mult_st && !mult_last) mult_cnt <= mult_cnt - 1'b1;
    else                           mult_cnt <= MULT_LD;
  end

  // A clear takes priority over an integrator write on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.Intgrl <= '0;
      dec_cnt    <= '0;
    end else if (bus.clr_intgrl) begin
      bus.Intgrl <= '0;
      dec_cnt    <= '0;
    end else if (state == INTG) begin
      if (dec_cnt == DEC_TOP) begin
        bus.Intgrl <= bus.dst[11:0];
        dec_cnt    <= '0;
      end else begin
        dec_cnt <= dec_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.Error <= '0;
      bus.Icomp <= '0;
      bus.Pcomp <= '0;
      bus.Accum <= '0;
      bus.done  <= 1'b0;
    end else begin
      bus.done <= (state == ACC2);
      if (state == ERR)                bus.Error <= bus.dst[11:0];
      if (state == ICMP && mult_last)  bus.Icomp <= bus.dst[11:0];
      if (state == PCMP && mult_last)  bus.Pcomp <= bus.dst;
      if (state == ACC1 || state == ACC2) bus.Accum <= bus.dst;
    end
  end

endmodule

// File: tb/tb_pid_math_seq.sv
// tb_pid_math_seq: directed bench for pid_math_seq. A behavioural model of
// the shared PID ALU closes the loop on dst; expected register values are
// hand-computed constants.
module tb_pid_math_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pid_math_seq_if bus ();

  pid_math_seq #(.MULT_CYC(2), .INT_DEC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared ALU model: sign-extended operands, 12-bit saturation on add/sub,
  // multiply keeps product bits [27:12] clamped to 16 bits.
  logic signed [15:0] s1, s0, sum;
  logic signed [14:0] m1, m0;
  logic signed [29:0] prod, psh;
  always_comb begin
    case (bus.src1sel)
      3'd0:    s1 = bus.Accum;
      3'd1:    s1 = {4'b0, bus.Iterm};
      3'd2:    s1 = {{4{bus.Error[11]}}, bus.Error};
      3'd3:    s1 = {{8{bus.Error[11]}}, bus.Error[11:4]};
      3'd4:    s1 = {4'b0, bus.Fwd};
      default: s1 = '0;
    endcase
    case (bus.src0sel)
      3'd0:    s0 = {4'b0, bus.A2D_res};
      3'd1:    s0 = {{4{bus.Intgrl[11]}}, bus.Intgrl};
      3'd2:    s0 = {{4{bus.Icomp[11]}}, bus.Icomp};
      3'd3:    s0 = bus.Pcomp;
      3'd4:    s0 = {2'b0, bus.Pterm};
      default: s0 = '0;
    endcase
    sum = bus.sub ? (s1 - s0) : (s1 + s0);
    if (bus.saturate) begin
      if (sum > 16'sd2047)       sum = 16'sh07FF;
      else if (sum < -16'sd2048) sum = 16'shF800;
    end
    m1   = s1[14:0];
    m0   = s0[14:0];
    prod = m1 * m0;
    psh  = prod >>> 12;
    if (!bus.multiply)         bus.dst = sum;
    else if (psh > 30'sd32767)  bus.dst = 16'h7FFF;
    else if (psh < -30'sd32768) bus.dst = 16'h8000;
    else                       bus.dst = psh[15:0];
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One sequence: strt for one cycle, optional clr_intgrl in the cycle after
  // edge E<clr_at>, returns edges from the start edge to done (-1 on timeout).
  task automatic run_seq(input int clr_at, output int lat);
    @(negedge clk);
    bus.strt = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      bus.strt       = 1'b0;
      bus.clr_intgrl = (n - 1 == clr_at);
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    bus.clr_intgrl = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 32'({bus.src1sel, bus.src0sel, bus.multiply, bus.sub,
                               bus.mult2, bus.mult4, bus.saturate, bus.busy, bus.done}), 0);
    check({tag, "_error"},  32'(bus.Error),  0);
    check({tag, "_intgrl"}, 32'(bus.Intgrl), 0);
    check({tag, "_icomp"},  32'(bus.Icomp),  0);
    check({tag, "_pcomp"},  32'(bus.Pcomp),  0);
    check({tag, "_accum"},  32'(bus.Accum),  0);
  endtask

  int lat;
  int ndone;

  initial begin
    rst_n          = 1'b0;
    bus.strt       = 1'b0;
    bus.clr_intgrl = 1'b0;
    bus.Fwd        = 12'h200;
    bus.A2D_res    = 12'h180;
    bus.Pterm      = 14'h3000;
    bus.Iterm      = 12'h010;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;

    // Reset asserted during the second PCMP cycle.
    @(negedge clk);
    bus.strt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.strt = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pcmp_sel", 32'({bus.src1sel, bus.src0sel, bus.multiply}), 32'h29);
    check("pre_rst_error", 32'(bus.Error), 32'h080);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 0);

    // Nominal run, four times: Intgrl only written on the fourth.
    for (int i = 0; i < 4; i++) begin
      run_seq(-1, lat);
      check("nom_latency", lat, 8);
      check("nom_error",  32'(bus.Error),  32'h080);
      check("nom_pcomp",  32'(bus.Pcomp),  32'h0180);
      check("nom_icomp",  32'(bus.Icomp),  32'h000);
      check("nom_accum",  32'(bus.Accum),  32'h0380);
      check("nom_intgrl", 32'(bus.Intgrl), (i == 3) ? 32'h008 : 32'h000);
    end
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(bus.done), 0);

    // Three more runs leave Intgrl at 0x008; the fourth would write 0x010 but
    // clr_intgrl during INTG wins.
    for (int i = 0; i < 3; i++) begin
      run_seq(-1, lat);
      check("dec_hold_intgrl", 32'(bus.Intgrl), 32'h008);
    end
    run_seq(1, lat);
    check("clr_latency", lat, 8);
    check("clr_intgrl", 32'(bus.Intgrl), 32'h000);

    // dec_cnt restarted from 0: next write lands on the fourth run.
    for (int i = 0; i < 4; i++) begin
      run_seq(-1, lat);
      check("post_clr_intgrl", 32'(bus.Intgrl), (i == 3) ? 32'h008 : 32'h000);
    end

    // Error saturation at both ends.
    bus.Fwd     = 12'h000;
    bus.A2D_res = 12'hFFF;
    run_seq(-1, lat);
    check("sat_neg_error", 32'(bus.Error), 32'h800);
    check("sat_neg_pcomp", 32'(bus.Pcomp), 32'hE800);
    check("sat_neg_accum", 32'(bus.Accum), 32'hF800);
    bus.Fwd     = 12'hFFF;
    bus.A2D_res = 12'h000;
    run_seq(-1, lat);
    check("sat_pos_error", 32'(bus.Error), 32'h7FF);
    check("sat_pos_pcomp", 32'(bus.Pcomp), 32'h17FD);
    check("sat_pos_accum", 32'(bus.Accum), 32'h07FF);
    bus.Fwd     = 12'h200;
    bus.A2D_res = 12'h180;

    // strt held high: one sequence every 9 cycles.
    @(negedge clk);
    bus.strt = 1'b1;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    check("held_first_done", 32'(lat > 0), 1);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    check("held_period", lat, 9);
    @(negedge clk);
    bus.strt = 1'b0;
    @(posedge clk);
    #1;
    check("held_stop_busy", 32'(bus.busy), 0);

    // A strt pulse while busy is dropped, not queued.
    @(negedge clk);
    bus.strt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.strt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.strt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.strt = 1'b0;
    ndone = 0;
    for (int n = 0; n < 22; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    check("busy_strt_ignored", 32'(ndone), 1);
    check("busy_strt_idle", 32'(bus.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
